// File: rtl/mem_bus_fabric_if.sv
// ============================================================================
// Module      : mem_bus_fabric_if
// Description : Request/response and slave-channel signals of mem_bus_fabric.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_fabric_if #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int NUM_SLV = 5
);
    logic                      m_valid;
    logic                      m_ready;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_we;
    logic                      m_rvalid;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_err;
    logic [NUM_SLV-1:0]        s_sel;
    logic                      s_we;
    logic [ADDR_W-1:0]         s_addr;
    logic [DATA_W-1:0]         s_wdata;
    logic [NUM_SLV-1:0]        s_ready;
    logic [NUM_SLV*DATA_W-1:0] s_rdata;

    // master: the surroundings (CPU plus slave devices); slave: the fabric itself
    modport master (
        output m_valid, m_addr, m_wdata, m_we, s_ready, s_rdata,
        input  m_ready, m_rvalid, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_we, s_ready, s_rdata,
        output m_ready, m_rvalid, m_rdata, m_err, s_sel, s_we, s_addr, s_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_fabric.sv
// ============================================================================
// Module      : mem_bus_fabric
// Description : Registered single-master region decoder with per-slave
//               ready handshake. Define BUS_TIMEOUT_EN for the ACCESS timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_fabric #(
    parameter int                         ADDR_W      = 16,
    parameter int                         DATA_W      = 16,
    parameter int                         NUM_SLV     = 5,
    parameter int                         RGN_W       = 4,
    parameter logic [NUM_SLV*RGN_W-1:0]   SLV_RGN     = 20'hBA840,
    parameter int                         TIMEOUT_CYC = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_bus_fabric_if.slave    bus
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_SLV-1:0]  sel_q,   sel_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q,   err_d;

    logic [RGN_W-1:0]    tag;
    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0]             cnt_q, cnt_d;
`endif

    assign tag = bus.m_addr[ADDR_W-1 -: RGN_W];

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (SLV_RGN[i*RGN_W +: RGN_W] == tag) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    assign sel_ready = bus.s_ready[idx_q];
    assign sel_rdata = bus.s_rdata[idx_q*DATA_W +: DATA_W];

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.m_valid) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                        sel_d   = NUM_SLV'(1) << dec_idx;
                        we_d    = bus.m_we;
                        idx_d   = dec_idx;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d  = ST_RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_d  = ST_RESP;
                    rvalid_d = 1'b1;
                    err_d    = 1'b0;
                    rdata_d  = we_q ? '0 : sel_rdata;
                    sel_d    = '0;
                    we_d     = 1'b0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_RESP;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    sel_d    = '0;
                    we_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.m_ready  = (state_q == ST_IDLE);
    assign bus.m_rvalid = rvalid_q;
    assign bus.m_rdata  = rdata_q;
    assign bus.m_err    = err_q;
    assign bus.s_sel    = sel_q;
    assign bus.s_we     = we_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;

endmodule

`default_nettype wire
